alu_exec_pipe: RTL and testbench
================================

ALU_EXEC_PIPE -- requirements
Module: alu_exec_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand/result width, >= 4.
REQ-002 SHALL have parameter HIST_DEPTH, default 2: number of retained past results, >= 1.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1: operation presented.
REQ-006 SHALL have port in_ready, output, 1: stage can accept; in_ready = !out_valid | out_ready.
REQ-007 SHALL have ports op_a and op_b, input, WIDTH: register operands.
REQ-008 SHALL have port imm, input, WIDTH: immediate operand.
REQ-009 SHALL have port alu_src, input, 1: 1 = operand B is imm, 0 = op_b.
REQ-010 SHALL have port alu_op, input, 4: operation code.
REQ-011 SHALL have port jump_type, input, 2: 0 none, 1 jump-if-Z, 2 jump-if-N, 3 jump-if-C.
REQ-012 SHALL have port flush, input, 1: discard in-flight and presented operation.
REQ-013 SHALL have port out_valid, output, 1: result registers hold valid operation.
REQ-014 SHALL have port out_ready, input, 1: downstream consumes result.
REQ-015 SHALL have port result, output, WIDTH: registered result.
REQ-016 SHALL have port flags, output, 3: architectural {C,Z,N}.
REQ-017 SHALL have port jump_taken, output, 1: registered jump decision, qualified by out_valid.
REQ-018 SHALL have port result_hist, output, WIDTH*HIST_DEPTH: slice k (bits k*WIDTH +: WIDTH) = result accepted k+1 operations before current result.

Function
REQ-019 Accept SHALL occur on a rising edge where in_valid & in_ready & !flush; result, jump_taken, out_valid=1 load on that edge (latency 1).
REQ-020 Output SHALL hold stable while out_valid & !out_ready; out_valid clears on consume with no new accept.
REQ-021 Ops SHALL be: 0 PASS_A, 1 PASS_B, 2 ADD, 3 SUB (A-B), 4 AND, 5 OR, 6 NOT A, 7 INC A, 8 DEC A, 9 SHL A by 1, 10 SHR A by 1 logical, 11 SETC, 12 CLRC; 13-15 NOP = PASS_A, no flag change.
REQ-022 Arithmetic SHALL be WIDTH-bit modulo; C = carry-out for ADD/INC, borrow (A<B unsigned) for SUB, borrow for DEC, shifted-out bit for SHL/SHR; SETC/CLRC set/clear C, result = A.
REQ-023 Z (result==0) and N (result MSB) SHALL update for ops 2-10; C SHALL update for ops 2,3,7-12; other flags unchanged.
REQ-024 Flags SHALL update only on accept, same edge as result.
REQ-025 jump_taken SHALL use flags value before the accepting operation's update (flags of previous flag-writer).
REQ-026 On each accept, history SHALL shift: slice0 <- current result, slice k <- slice k-1; oldest discarded; no shift without accept.
REQ-027 flush SHALL clear out_valid and jump_taken next edge, block accept that edge, leave flags, result and history unchanged; flush wins over simultaneous accept and out_ready.

Reset
REQ-028 rst SHALL on edge clear out_valid, jump_taken, result, flags (C=Z=N=0), all history slices to 0; rst dominates flush and in_valid.
REQ-029 rst asserted mid-stall SHALL drop pending result; in_ready = 1 the cycle after rst deasserts.

Verification
REQ-030 ADD 0xFFFF+0x0001 (WIDTH=16) -> next cycle result 0x0000, flags C=1,Z=1,N=0, out_valid=1.
REQ-031 SUB 3-5 then op 1 with jump_type=3 -> first result 0xFFFE, C=1,N=1; second jump_taken=1 and flags unchanged.
REQ-032 Hold out_ready=0 with out_valid=1 for 3 cycles while in_valid=1 -> in_ready=0, result/flags/history unchanged, no accept.
REQ-033 Accept results 0x0011, 0x0022, 0x0033 (HIST_DEPTH=2) -> result 0x0033, slice0 0x0022, slice1 0x0011.
REQ-034 flush same cycle as valid ADD -> out_valid=0 next cycle, flags and history unchanged.
REQ-035 rst asserted during stall with pending result -> next cycle out_valid=0, result=0, flags=0, history=0, in_ready=1.

Source files
------------

// File: rtl/alu_exec_pipe.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_pipe
// Brief    : Single-stage ALU execute pipe with valid/ready handshake, flags,
//            conditional jump decision and a shift history of past results.
// Revision : 1.0
// ============================================================================
module alu_exec_pipe #(
    parameter int WIDTH      = 16,
    parameter int HIST_DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            op_a,
    input  logic [WIDTH-1:0]            op_b,
    input  logic [WIDTH-1:0]            imm,
    input  logic                        alu_src,
    input  logic [3:0]                  alu_op,
    input  logic [1:0]                  jump_type,
    input  logic                        flush,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH-1:0]            result,
    output logic [2:0]                  flags,
    output logic                        jump_taken,
    output logic [WIDTH*HIST_DEPTH-1:0] result_hist
);

    localparam logic [3:0] OP_PASS_A = 4'd0;
    localparam logic [3:0] OP_PASS_B = 4'd1;
    localparam logic [3:0] OP_ADD    = 4'd2;
    localparam logic [3:0] OP_SUB    = 4'd3;
    localparam logic [3:0] OP_AND    = 4'd4;
    localparam logic [3:0] OP_OR     = 4'd5;
    localparam logic [3:0] OP_NOT    = 4'd6;
    localparam logic [3:0] OP_INC    = 4'd7;
    localparam logic [3:0] OP_DEC    = 4'd8;
    localparam logic [3:0] OP_SHL    = 4'd9;
    localparam logic [3:0] OP_SHR    = 4'd10;
    localparam logic [3:0] OP_SETC   = 4'd11;
    localparam logic [3:0] OP_CLRC   = 4'd12;

    logic [WIDTH-1:0] opnd_b;
    logic [WIDTH:0]   ext;
    logic [WIDTH-1:0] alu_res;
    logic             c_nxt;
    logic             z_nxt;
    logic             n_nxt;
    logic             upd_zn;
    logic             jump_nxt;
    logic             accept;
    logic [WIDTH-1:0] hist_q [HIST_DEPTH];

    assign in_ready = !out_valid | out_ready;
    assign accept   = in_valid & in_ready & !flush;
    assign opnd_b   = alu_src ? imm : op_b;

    // flags is {C,Z,N}; ops that do not write a flag pass its old value through
    always_comb begin
        ext     = '0;
        alu_res = op_a;
        c_nxt   = flags[2];
        z_nxt   = flags[1];
        n_nxt   = flags[0];
        upd_zn  = 1'b0;
        case (alu_op)
            OP_PASS_A: alu_res = op_a;
            OP_PASS_B: alu_res = opnd_b;
            OP_ADD: begin
                ext     = {1'b0, op_a} + {1'b0, opnd_b};
                alu_res = ext[WIDTH-1:0];
                c_nxt   = ext[WIDTH];
                upd_zn  = 1'b1;
            end
            OP_SUB: begin
                ext     = {1'b0, op_a} - {1'b0, opnd_b};
                alu_res = ext[WIDTH-1:0];
                c_nxt   = ext[WIDTH];
                upd_zn  = 1'b1;
            end
            OP_AND: begin
                alu_res = op_a & opnd_b;
                upd_zn  = 1'b1;
            end
            OP_OR: begin
                alu_res = op_a | opnd_b;
                upd_zn  = 1'b1;
            end
            OP_NOT: begin
                alu_res = ~op_a;
                upd_zn  = 1'b1;
            end
            OP_INC: begin
                ext     = {1'b0, op_a} + (WIDTH+1)'(1);
                alu_res = ext[WIDTH-1:0];
                c_nxt   = ext[WIDTH];
                upd_zn  = 1'b1;
            end
            OP_DEC: begin
                ext     = {1'b0, op_a} - (WIDTH+1)'(1);
                alu_res = ext[WIDTH-1:0];
                c_nxt   = ext[WIDTH];
                upd_zn  = 1'b1;
            end
            OP_SHL: begin
                alu_res = {op_a[WIDTH-2:0], 1'b0};
                c_nxt   = op_a[WIDTH-1];
                upd_zn  = 1'b1;
            end
            OP_SHR: begin
                alu_res = {1'b0, op_a[WIDTH-1:1]};
                c_nxt   = op_a[0];
                upd_zn  = 1'b1;
            end
            OP_SETC: c_nxt = 1'b1;
            OP_CLRC: c_nxt = 1'b0;
            default: alu_res = op_a;
        endcase
        if (upd_zn) begin
            z_nxt = (alu_res == '0);
            n_nxt = alu_res[WIDTH-1];
        end
    end

    // Jump decision looks at the flags as they stand before this op writes them
    always_comb begin
        case (jump_type)
            2'd1:    jump_nxt = flags[1];
            2'd2:    jump_nxt = flags[0];
            2'd3:    jump_nxt = flags[2];
            default: jump_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            jump_taken <= 1'b0;
            result     <= '0;
            flags      <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            jump_taken <= 1'b0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            jump_taken <= jump_nxt;
            result     <= alu_res;
            flags      <= {c_nxt, z_nxt, n_nxt};
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

    // History pushes the result being replaced, so slice 0 is one op back
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < HIST_DEPTH; k++) hist_q[k] <= '0;
        end else if (accept) begin
            hist_q[0] <= result;
            for (int k = 1; k < HIST_DEPTH; k++) hist_q[k] <= hist_q[k-1];
        end
    end

    generate
        for (genvar g = 0; g < HIST_DEPTH; g++) begin : g_hist_out
            assign result_hist[g*WIDTH +: WIDTH] = hist_q[g];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_exec_pipe
// Brief    : Directed vector bench for alu_exec_pipe (WIDTH=16, HIST_DEPTH=2).
// Revision : 1.0
// ============================================================================
module tb_alu_exec_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [15:0] imm;
    logic        alu_src;
    logic [3:0]  alu_op;
    logic [1:0]  jump_type;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic [2:0]  flags;
    logic        jump_taken;
    logic [31:0] result_hist;

    int n_cmp = 0;
    int n_bad = 0;

    alu_exec_pipe #(.WIDTH(16), .HIST_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .imm(imm), .alu_src(alu_src),
        .alu_op(alu_op), .jump_type(jump_type), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .flags(flags), .jump_taken(jump_taken), .result_hist(result_hist)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] im;
        logic        src;
        logic [1:0]  jt;
        logic [15:0] exp_res;
        logic [2:0]  exp_flg;   // {C,Z,N}
        logic        exp_jmp;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] im, input logic src, input logic [1:0] jt);
        alu_op = op; op_a = a; op_b = b; imm = im; alu_src = src; jump_type = jt;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] h0, h1;

        vecs[0]  = '{4'd2,  16'hFFFF, 16'h0001, 16'h0000, 1'b0, 2'd0, 16'h0000, 3'b110, 1'b0};
        vecs[1]  = '{4'd3,  16'h0003, 16'h0005, 16'h0000, 1'b0, 2'd1, 16'hFFFE, 3'b101, 1'b1};
        vecs[2]  = '{4'd1,  16'h0000, 16'h1234, 16'h0000, 1'b0, 2'd3, 16'h1234, 3'b101, 1'b1};
        vecs[3]  = '{4'd4,  16'hF0F0, 16'h0FF0, 16'h0000, 1'b0, 2'd2, 16'h00F0, 3'b100, 1'b1};
        vecs[4]  = '{4'd5,  16'h0F00, 16'hFFFF, 16'h00F0, 1'b1, 2'd2, 16'h0FF0, 3'b100, 1'b0};
        vecs[5]  = '{4'd6,  16'h00FF, 16'h0000, 16'h0000, 1'b0, 2'd3, 16'hFF00, 3'b101, 1'b1};
        vecs[6]  = '{4'd7,  16'hFFFF, 16'h0000, 16'h0000, 1'b0, 2'd1, 16'h0000, 3'b110, 1'b0};
        vecs[7]  = '{4'd8,  16'h0000, 16'h0000, 16'h0000, 1'b0, 2'd1, 16'hFFFF, 3'b101, 1'b1};
        vecs[8]  = '{4'd9,  16'h8001, 16'h0000, 16'h0000, 1'b0, 2'd0, 16'h0002, 3'b100, 1'b0};
        vecs[9]  = '{4'd10, 16'h0003, 16'h0000, 16'h0000, 1'b0, 2'd2, 16'h0001, 3'b100, 1'b0};
        vecs[10] = '{4'd12, 16'h8000, 16'h0000, 16'h0000, 1'b0, 2'd3, 16'h8000, 3'b000, 1'b1};
        vecs[11] = '{4'd11, 16'h0000, 16'h0000, 16'h0000, 1'b0, 2'd3, 16'h0000, 3'b100, 1'b0};
        vecs[12] = '{4'd13, 16'hABCD, 16'h1111, 16'h0000, 1'b0, 2'd3, 16'hABCD, 3'b100, 1'b1};
        vecs[13] = '{4'd0,  16'h0000, 16'h5555, 16'h0000, 1'b0, 2'd1, 16'h0000, 3'b100, 1'b0};
        vecs[14] = '{4'd3,  16'h0005, 16'h0003, 16'h0000, 1'b0, 2'd0, 16'h0002, 3'b000, 1'b0};
        vecs[15] = '{4'd2,  16'h7FFF, 16'h9999, 16'h0001, 1'b1, 2'd2, 16'h8000, 3'b001, 1'b0};

        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        set_op(4'd0, 16'h0, 16'h0, 16'h0, 1'b0, 2'd0);
        step(); step();
        rst = 1'b0;
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_result", {16'b0, result}, 32'd0);
        chk("reset_flags", {29'b0, flags}, 32'd0);
        chk("reset_hist", result_hist, 32'd0);
        chk("reset_in_ready", {31'b0, in_ready}, 32'd1);

        h0 = 16'h0; h1 = 16'h0;
        for (int i = 0; i < 16; i++) begin
            set_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].im, vecs[i].src, vecs[i].jt);
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            chk($sformatf("vec%0d_valid", i), {31'b0, out_valid}, 32'd1);
            chk($sformatf("vec%0d_result", i), {16'b0, result}, {16'b0, vecs[i].exp_res});
            chk($sformatf("vec%0d_flags", i), {29'b0, flags}, {29'b0, vecs[i].exp_flg});
            chk($sformatf("vec%0d_jump", i), {31'b0, jump_taken}, {31'b0, vecs[i].exp_jmp});
            chk($sformatf("vec%0d_hist", i), result_hist, {h1, h0});
            h1 = h0;
            h0 = vecs[i].exp_res;
        end

        // Stall: downstream not ready, new op presented, nothing may move
        out_ready = 1'b0;
        set_op(4'd2, 16'h0001, 16'h0001, 16'h0, 1'b0, 2'd0);
        in_valid = 1'b1;
        #1;
        chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("stall%0d_in_ready", c), {31'b0, in_ready}, 32'd0);
            chk($sformatf("stall%0d_valid", c), {31'b0, out_valid}, 32'd1);
            chk($sformatf("stall%0d_result", c), {16'b0, result}, 32'h8000);
            chk($sformatf("stall%0d_flags", c), {29'b0, flags}, 32'b001);
            chk($sformatf("stall%0d_hist", c), result_hist, 32'h0000_0002);
        end

        // Consume with no new op clears out_valid
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        chk("consume_valid", {31'b0, out_valid}, 32'd0);
        chk("consume_result", {16'b0, result}, 32'h8000);

        // Three back-to-back accepts build the history
        in_valid = 1'b1;
        set_op(4'd0, 16'h0011, 16'h0, 16'h0, 1'b0, 2'd0); step();
        set_op(4'd0, 16'h0022, 16'h0, 16'h0, 1'b0, 2'd0); step();
        set_op(4'd0, 16'h0033, 16'h0, 16'h0, 1'b0, 2'd2); step();
        in_valid = 1'b0;
        chk("hist3_result", {16'b0, result}, 32'h0033);
        chk("hist3_hist", result_hist, 32'h0011_0022);
        chk("hist3_jump", {31'b0, jump_taken}, 32'd1);

        // Flush beats a simultaneous valid ADD and out_ready
        set_op(4'd2, 16'hFFFF, 16'h0001, 16'h0, 1'b0, 2'd0);
        in_valid = 1'b1; flush = 1'b1;
        step();
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_valid", {31'b0, out_valid}, 32'd0);
        chk("flush_jump", {31'b0, jump_taken}, 32'd0);
        chk("flush_result", {16'b0, result}, 32'h0033);
        chk("flush_flags", {29'b0, flags}, 32'b001);
        chk("flush_hist", result_hist, 32'h0011_0022);

        // Reset during a stall drops the pending result
        out_ready = 1'b0;
        set_op(4'd0, 16'h5555, 16'h0, 16'h0, 1'b0, 2'd0);
        in_valid = 1'b1;
        step();
        chk("prerst_valid", {31'b0, out_valid}, 32'd1);
        chk("prerst_result", {16'b0, result}, 32'h5555);
        rst = 1'b1;
        step();
        rst = 1'b0; in_valid = 1'b0;
        chk("rst_stall_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_stall_result", {16'b0, result}, 32'd0);
        chk("rst_stall_flags", {29'b0, flags}, 32'd0);
        chk("rst_stall_hist", result_hist, 32'd0);
        chk("rst_stall_in_ready", {31'b0, in_ready}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
